// File: rtl/eth_rx_seq_ctrl_if.sv
// RX pipe, DMA output stream and TX ack handshake bundled for eth_rx_seq_ctrl.
// master = upstream/downstream environment, slave = the sequencer itself.
interface eth_rx_seq_ctrl_if;
  logic        in_start;
  logic        in_data_v;
  logic        in_end;
  logic [31:0] in_data;
  logic [7:0]  in_ptype;
  logic [7:0]  in_pid;
  logic [15:0] in_seqnum;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  logic        ack_valid;
  logic        ack_ready;
  logic [7:0]  ack_pid;
  logic [15:0] ack_seqnum;

  modport master (
    output in_start, in_data_v, in_end, in_data, in_ptype, in_pid, in_seqnum,
    output out_ready, ack_ready,
    input  out_valid, out_data, out_last, ack_valid, ack_pid, ack_seqnum
  );

  modport slave (
    input  in_start, in_data_v, in_end, in_data, in_ptype, in_pid, in_seqnum,
    input  out_ready, ack_ready,
    output out_valid, out_data, out_last, ack_valid, ack_pid, ack_seqnum
  );
endinterface

// File: rtl/eth_rx_seq_ctrl.sv
// RX sequencer: admits in-order packets per pid, buffers them store-and-forward,
// releases whole packets to the DMA side and queues acks for the TX ring.
module eth_rx_seq_ctrl #(
  parameter int NPID  = 4,
  parameter int DEPTH = 512,
  parameter int ACKQ  = 4
) (
  input  logic             clk,
  input  logic             reset,
  eth_rx_seq_ctrl_if.slave rx,
  input  logic             seq_clr,
  output logic [15:0]      drop_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int QW   = $clog2(ACKQ);
  localparam int AQW  = QW + 1;
  localparam int PIDW = (NPID > 1) ? $clog2(NPID) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state, state_d;
  logic [31:0]   hold_word;
  logic [7:0]    cur_pid;
  logic [15:0]   cur_seq;
  logic [15:0]   exp_q [NPID];

  logic [PW-1:0] wr_ptr, wr_commit, rd_ptr;
  logic [32:0]   mem [DEPTH];
  logic [32:0]   ram_q;
  logic          s1_v;

  logic [23:0]   ack_mem [ACKQ];
  logic [AQW-1:0] ack_wp, ack_rp;

  logic          pid_ok, buf_full, ack_full, ack_pop;
  logic [15:0]   exp_sel;
  logic          abort, start_recv, start_drop, overflow;
  logic          wr_en, wr_last, commit, push_ack;
  logic [23:0]   ack_word;
  logic [1:0]    drop_inc;
  logic          rd_en, load_out;

  // Classification, write-side control and next state, all from pre-edge values.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d    = state;
    abort      = 1'b0;
    start_recv = 1'b0;
    start_drop = 1'b0;
    overflow   = 1'b0;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    commit     = 1'b0;
    push_ack   = 1'b0;
    ack_word   = '0;
    pid_ok     = (rx.in_pid < 8'(NPID));
    exp_sel    = exp_q[rx.in_pid[PIDW-1:0]];
    buf_full   = (wr_ptr - rd_ptr) == PW'(DEPTH);

    if (rx.in_start) begin
      abort = (state == S_RECV);
      if (!pid_ok) begin
        start_drop = 1'b1;
      end else if (rx.in_seqnum == exp_sel) begin
        start_recv = 1'b1;
      end else if (rx.in_seqnum == exp_sel - 16'd1) begin
        // Duplicate of the last committed packet: its ack may have been lost.
        start_drop = 1'b1;
        push_ack   = 1'b1;
        ack_word   = {rx.in_pid, rx.in_seqnum};
      end else begin
        start_drop = 1'b1;
      end
      state_d = start_recv ? S_RECV : S_DROP;
    end else if (state == S_RECV && (rx.in_data_v || rx.in_end)) begin
      if (buf_full) begin
        overflow = 1'b1;
        state_d  = S_DROP;
      end else begin
        wr_en   = 1'b1;
        wr_last = rx.in_end;
        if (rx.in_end) begin
          commit   = 1'b1;
          push_ack = 1'b1;
          ack_word = {cur_pid, cur_seq};
          state_d  = S_IDLE;
        end
      end
    end else if (state == S_DROP && rx.in_end) begin
      state_d = S_IDLE;
    end

    drop_inc = 2'(abort) + 2'(start_drop) + 2'(overflow);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      hold_word <= '0;
      cur_pid   <= '0;
      cur_seq   <= '0;
      wr_ptr    <= '0;
      wr_commit <= '0;
      drop_cnt  <= '0;
      for (int i = 0; i < NPID; i++) exp_q[i] <= '0;
    end else begin
      state    <= state_d;
      drop_cnt <= drop_cnt + 16'(drop_inc);

      // Abort and overflow discard everything written since the last commit.
      if (abort || overflow) wr_ptr <= wr_commit;
      else if (wr_en)        wr_ptr <= wr_ptr + 1'b1;

      if (commit) wr_commit <= wr_ptr + 1'b1;

      if (start_recv) begin
        hold_word <= {rx.in_seqnum, rx.in_pid, rx.in_ptype};
        cur_pid   <= rx.in_pid;
        cur_seq   <= rx.in_seqnum;
      end else if (wr_en && !wr_last) begin
        hold_word <= rx.in_data;
      end

      if (seq_clr) begin
        for (int i = 0; i < NPID; i++) exp_q[i] <= '0;
      end else if (commit) begin
        exp_q[cur_pid[PIDW-1:0]] <= exp_q[cur_pid[PIDW-1:0]] + 16'd1;
      end
    end
  end

  // NOTE: the packet RAM has no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {wr_last, hold_word};
    if (rd_en) ram_q <= mem[rd_ptr[AW-1:0]];
  end

  // Two-stage read: RAM output stage (s1) feeding the output register.
  assign load_out = s1_v && (!rx.out_valid || rx.out_ready);
  assign rd_en    = (rd_ptr != wr_commit) && (!s1_v || load_out);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      s1_v         <= 1'b0;
      rx.out_valid <= 1'b0;
      rx.out_data  <= '0;
      rx.out_last  <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;

      if (rd_en)         s1_v <= 1'b1;
      else if (load_out) s1_v <= 1'b0;

      if (load_out) begin
        rx.out_valid <= 1'b1;
        rx.out_data  <= ram_q[31:0];
        rx.out_last  <= ram_q[32];
      end else if (rx.out_ready) begin
        rx.out_valid <= 1'b0;
      end
    end
  end

  // Ack FIFO, first-word-fall-through; a push into a full queue is discarded.
  assign ack_full      = (ack_wp - ack_rp) == AQW'(ACKQ);
  assign rx.ack_valid  = (ack_wp != ack_rp);
  assign ack_pop       = rx.ack_valid && rx.ack_ready;
  assign rx.ack_pid    = ack_mem[ack_rp[QW-1:0]][23:16];
  assign rx.ack_seqnum = ack_mem[ack_rp[QW-1:0]][15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_wp <= '0;
      ack_rp <= '0;
      for (int i = 0; i < ACKQ; i++) ack_mem[i] <= '0;
    end else begin
      if (push_ack && !ack_full) begin
        ack_mem[ack_wp[QW-1:0]] <= ack_word;
        ack_wp                  <= ack_wp + 1'b1;
      end
      if (ack_pop) ack_rp <= ack_rp + 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_rx_seq_ctrl.sv
// Scoreboard bench for eth_rx_seq_ctrl: expected words/acks are queued as
// packets are driven and compared as the DUT hands them out.
module tb_eth_rx_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seq_clr = 1'b0;
  logic [15:0] drop_cnt;

  eth_rx_seq_ctrl_if rx();

  eth_rx_seq_ctrl #(.NPID(4), .DEPTH(16), .ACKQ(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .seq_clr  (seq_clr),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [32:0] out_q[$];
  logic [23:0] ack_q[$];
  bit          toggle_rdy = 1'b0;
  int          exp_drop = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_rdy) rx.out_ready = ~rx.out_ready;
  endtask

  task automatic drive(input bit s, input bit dv, input bit e, input logic [31:0] d,
                       input logic [7:0] pt, input logic [7:0] pid, input logic [15:0] sq);
    tick();
    rx.in_start  = s;
    rx.in_data_v = dv;
    rx.in_end    = e;
    rx.in_data   = d;
    rx.in_ptype  = pt;
    rx.in_pid    = pid;
    rx.in_seqnum = sq;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic send_pkt(input logic [7:0] pid, input logic [15:0] seq, input int n,
                          input logic [31:0] base, input bit accept, input bit do_ack,
                          input bit clr_end);
    logic [7:0]  pt;
    logic [31:0] w;
    pt = 8'hA0 + pid;
    if (accept) begin
      out_q.push_back({n == 0, seq, pid, pt});
      for (int i = 0; i < n; i++) begin
        w = base + 32'(i) * 32'h1111_1111;
        out_q.push_back({i == n - 1, w});
      end
    end
    if (do_ack) ack_q.push_back({pid, seq});
    drive(1'b1, 1'b0, 1'b0, '0, pt, pid, seq);
    for (int i = 0; i < n; i++) begin
      w = base + 32'(i) * 32'h1111_1111;
      drive(1'b0, 1'b1, 1'b0, w, '0, '0, '0);
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
    seq_clr = clr_end;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    seq_clr = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && (out_q.size() != 0 || ack_q.size() != 0); c++) tick();
    idle(6);
    check("drain_out", out_q.size(), 0);
    check("drain_ack", ack_q.size(), 0);
  endtask

  // Output/ack monitor, sampled on the falling edge.
  initial begin : mon
    bit          stall;
    logic [32:0] held;
    logic [32:0] want_w;
    logic [23:0] want_a;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
        continue;
      end
      if (stall) check("out_hold", {rx.out_valid, rx.out_last, rx.out_data}, {1'b1, held});
      stall = rx.out_valid && !rx.out_ready;
      held  = {rx.out_last, rx.out_data};
      if (rx.out_valid && rx.out_ready) begin
        check("out_pending", out_q.size() != 0, 1);
        if (out_q.size() != 0) begin
          want_w = out_q.pop_front();
          check("out_word", {rx.out_last, rx.out_data}, want_w);
        end
      end
      if (rx.ack_valid && rx.ack_ready) begin
        check("ack_pending", ack_q.size() != 0, 1);
        if (ack_q.size() != 0) begin
          want_a = ack_q.pop_front();
          check("ack_word", {rx.ack_pid, rx.ack_seqnum}, want_a);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rx.in_start = 1'b0; rx.in_data_v = 1'b0; rx.in_end = 1'b0; rx.in_data = '0;
    rx.in_ptype = '0;   rx.in_pid = '0;      rx.in_seqnum = '0;
    rx.out_ready = 1'b1; rx.ack_ready = 1'b1;

    // Reset values
    idle(3);
    check("rst_out", {rx.out_valid, rx.out_last, rx.out_data}, 0);
    check("rst_ack", {rx.ack_valid, rx.ack_pid, rx.ack_seqnum}, 0);
    check("rst_drop", drop_cnt, 0);
    reset = 1'b0;
    idle(2);

    // In-order packet: pid1 seq0, two payload words
    send_pkt(8'd1, 16'd0, 2, 32'h1111_1111, 1'b1, 1'b1, 1'b0);
    drain(100);
    check("inorder_drop", drop_cnt, 0);

    // Duplicate (re-ack), stale, invalid pid, then the next in-order header-only
    send_pkt(8'd1, 16'd0, 1, 32'hDEAD_0000, 1'b0, 1'b1, 1'b0);
    send_pkt(8'd1, 16'd5, 1, 32'hDEAD_1000, 1'b0, 1'b0, 1'b0);
    send_pkt(8'd7, 16'd0, 1, 32'hDEAD_2000, 1'b0, 1'b0, 1'b0);
    exp_drop = 3;
    send_pkt(8'd1, 16'd1, 0, '0, 1'b1, 1'b1, 1'b0);
    drain(100);
    check("dup_stale_drop", drop_cnt, 16'(exp_drop));

    // Overflow: 10-word packet fits, the following 10-word packet cannot
    rx.out_ready = 1'b0;
    send_pkt(8'd0, 16'd0, 9, 32'h3000_0000, 1'b1, 1'b1, 1'b0);
    send_pkt(8'd0, 16'd1, 9, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    idle(3);
    exp_drop++;
    check("ovf_drop", drop_cnt, 16'(exp_drop));
    check("ovf_stalled", out_q.size(), 10);
    rx.out_ready = 1'b1;
    drain(200);
    send_pkt(8'd0, 16'd1, 0, '0, 1'b1, 1'b1, 1'b0);
    drain(100);

    // Missing end: first packet aborted by a new start
    out_q.push_back({1'b0, 16'd0, 8'd2, 8'hB2});
    out_q.push_back({1'b1, 32'hBEEF_0001});
    ack_q.push_back({8'd2, 16'd0});
    drive(1'b1, 1'b0, 1'b0, '0, 8'hB2, 8'd2, 16'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 32'hCAFE_0000 + 32'(i), '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, 8'hB2, 8'd2, 16'd0);
    drive(1'b0, 1'b1, 1'b0, 32'hBEEF_0001, '0, '0, '0);
    drive(1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
    idle(1);
    exp_drop++;
    drain(100);
    check("abort_drop", drop_cnt, 16'(exp_drop));

    // Back-pressure: out_ready toggles every cycle
    toggle_rdy = 1'b1;
    for (int k = 0; k < 3; k++)
      send_pkt(8'd3, 16'(k), int'($urandom_range(0, 4)), $urandom, 1'b1, 1'b1, 1'b0);
    drain(300);
    toggle_rdy   = 1'b0;
    rx.out_ready = 1'b1;

    // Ack queue full: 5 commits, only 4 acks survive
    rx.ack_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      send_pkt(8'd1, 16'(2 + k), 1, 32'h5000_0000 + 32'(k), 1'b1, k < 4, 1'b0);
    idle(30);
    check("ackq_out_done", out_q.size(), 0);
    check("ackq_held", {rx.ack_valid, rx.ack_pid, rx.ack_seqnum}, {1'b1, 8'd1, 16'd2});
    rx.ack_ready = 1'b1;
    drain(100);
    check("ackq_drop", drop_cnt, 16'(exp_drop));

    // Async reset in the middle of a packet, with a committed packet stalled
    rx.out_ready = 1'b0;
    rx.ack_ready = 1'b0;
    send_pkt(8'd0, 16'd2, 2, 32'h6000_0000, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 8'hA0, 8'd0, 16'd3);
    drive(1'b0, 1'b1, 1'b0, 32'h7000_0000, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 32'h7000_0001, '0, '0, '0);
    check("pre_rst_busy", {rx.out_valid, rx.ack_valid}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("arst_out", {rx.out_valid, rx.out_last, rx.out_data}, 0);
    check("arst_ack", {rx.ack_valid, rx.ack_pid, rx.ack_seqnum}, 0);
    check("arst_drop", drop_cnt, 0);
    out_q.delete();
    ack_q.delete();
    exp_drop = 0;
    idle(2);
    reset = 1'b0;
    rx.out_ready = 1'b1;
    rx.ack_ready = 1'b1;
    idle(20);
    send_pkt(8'd0, 16'd0, 0, '0, 1'b1, 1'b1, 1'b0);
    drain(100);

    // seq_clr together with a commit wins over the increment
    send_pkt(8'd0, 16'd1, 1, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    send_pkt(8'd0, 16'd0, 1, 32'h9000_0000, 1'b1, 1'b1, 1'b0);
    drain(100);
    check("clr_drop", drop_cnt, 16'(exp_drop));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
